// File: rtl/echo_width_meter_if.sv
// Echo width meter bus: arm pulse, raw echo pin, result and status.
// master drives start/echo; slave (the meter) drives the results.
interface echo_width_meter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             echo;
  logic [WIDTH-1:0] width_us;
  logic             valid;
  logic             timeout;
  logic             busy;

  modport master (
    output start,
    output echo,
    input  width_us,
    input  valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  start,
    input  echo,
    output width_us,
    output valid,
    output timeout,
    output busy
  );
endinterface

// File: rtl/echo_width_meter.sv
// Times the echo high-time in us after each start; one valid or timeout per start.
// Ports: clk, rst (async, active-low), bus (start/echo in; width_us/valid/timeout/busy out).
module echo_width_meter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_DIV   = 100,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT_US = 38000
) (
  input  logic clk,
  input  logic rst,
  echo_width_meter_if.slave bus
);

  if (CLK_HZ != TICK_DIV * 1_000_000) begin : g_bad_clk
    $error("CLK_HZ must equal TICK_DIV * 1 MHz");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end
  if (TIMEOUT_US >= (2 ** WIDTH)) begin : g_bad_tmo
    $error("TIMEOUT_US must fit in WIDTH bits");
  end

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT_US);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t           state_q;
  logic             sync_q;
  logic             es_q;
  logic             ed_q;
  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] width_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy_q;

  logic             rise;
  logic             fall;
  logic             tick;
  logic             at_lim;
  logic [WIDTH-1:0] width_d;

  assign rise   = es_q & ~ed_q;
  assign fall   = ~es_q & ed_q;
  assign tick   = (pre_q == PRE_MAX);
  assign at_lim = (cnt_q == TMO);
  // The tick due this very cycle is counted so the result is floor(H/TICK_DIV).
  assign width_d = cnt_q + WIDTH'(tick);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
      es_q   <= 1'b0;
      ed_q   <= 1'b0;
    end else begin
      sync_q <= bus.echo;
      es_q   <= sync_q;
      ed_q   <= es_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      pre_q     <= tick ? '0 : pre_q + 1'b1;
      if (tick) cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            pre_q   <= '0;
          end
        end
        ARM: begin
          // Timeout has priority over a coincident rising edge.
          if (at_lim) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            pre_q     <= '0;
            cnt_q     <= '0;
          end else if (rise) begin
            state_q <= MEASURE;
            pre_q   <= '0;
            cnt_q   <= '0;
          end
        end
        MEASURE: begin
          // A falling edge beats a coincident timeout.
          if (fall) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            width_q <= width_d;
            pre_q   <= '0;
            cnt_q   <= '0;
          end else if (at_lim) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            pre_q     <= '0;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pre_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.width_us = width_q;
  assign bus.valid    = valid_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_echo_width_meter.sv
// Directed bench for echo_width_meter with a result scoreboard.
// Two instances: default timeout (a) and TIMEOUT_US = 50 (b).
module tb_echo_width_meter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  echo_width_meter_if #(.WIDTH(16)) ifa ();
  echo_width_meter_if #(.WIDTH(16)) ifb ();

  echo_width_meter #(
    .TICK_DIV(100)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  echo_width_meter #(
    .TICK_DIV(100),
    .TIMEOUT_US(50)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  typedef struct packed {
    logic        to;
    logic [15:0] w;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int passed = 0;
  int n;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ifa.valid || ifa.timeout) begin
      chk("a_excl", 32'(ifa.valid & ifa.timeout), 0);
      if (qa.size() == 0) begin
        chk("a_unexpected_pulse", qa.size(), 1);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_kind", 32'(ifa.timeout), 32'(e.to));
        chk("a_width", 32'(ifa.width_us), 32'(e.w));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.valid || ifb.timeout) begin
      chk("b_excl", 32'(ifb.valid & ifb.timeout), 0);
      if (qb.size() == 0) begin
        chk("b_unexpected_pulse", qb.size(), 1);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_kind", 32'(ifb.timeout), 32'(e.to));
        chk("b_width", 32'(ifb.width_us), 32'(e.w));
      end
    end
  end

  initial begin
    rst = 1'b0;
    ifa.start = 1'b0;
    ifa.echo  = 1'b0;
    ifb.start = 1'b0;
    ifb.echo  = 1'b0;
    cyc(3);
    chk("rst_width", 32'(ifa.width_us), 0);
    chk("rst_valid", 32'(ifa.valid), 0);
    chk("rst_timeout", 32'(ifa.timeout), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    rst = 1'b1;
    cyc(2);

    // nominal 58000-cycle pulse
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    chk("busy_rise", 32'(ifa.busy), 1);
    cyc(500);
    qa.push_back('{to: 1'b0, w: 16'd580});
    ifa.echo = 1'b1;
    cyc(58000);
    ifa.echo = 1'b0;
    cyc(2);
    chk("nom_busy_hold", 32'(ifa.busy), 1);
    cyc(1);
    chk("nom_busy_fall", 32'(ifa.busy), 0);
    chk("nom_valid", 32'(ifa.valid), 1);
    chk("nom_width", 32'(ifa.width_us), 580);
    cyc(5);

    // rounding: 199 -> 1, 200 -> 2
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(10);
    qa.push_back('{to: 1'b0, w: 16'd1});
    ifa.echo = 1'b1;
    cyc(199);
    ifa.echo = 1'b0;
    cyc(10);
    chk("round_199", 32'(ifa.width_us), 1);
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(10);
    qa.push_back('{to: 1'b0, w: 16'd2});
    ifa.echo = 1'b1;
    cyc(200);
    ifa.echo = 1'b0;
    cyc(10);
    chk("round_200", 32'(ifa.width_us), 2);

    // echo already high at arm; second start during MEASURE ignored
    ifa.echo = 1'b1;
    cyc(20);
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(300);
    chk("hi_arm_busy", 32'(ifa.busy), 1);
    ifa.echo = 1'b0;
    cyc(50);
    qa.push_back('{to: 1'b0, w: 16'd4});
    ifa.echo = 1'b1;
    cyc(100);
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(299);
    ifa.echo = 1'b0;
    cyc(10);
    chk("hi_busy_end", 32'(ifa.busy), 0);
    chk("hi_width", 32'(ifa.width_us), 4);

    // instance b: reference measurement 300 -> 3
    ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    cyc(10);
    qb.push_back('{to: 1'b0, w: 16'd3});
    ifb.echo = 1'b1;
    cyc(300);
    ifb.echo = 1'b0;
    cyc(10);
    chk("b_ref_width", 32'(ifb.width_us), 3);

    // ARM timeout with echo low
    qb.push_back('{to: 1'b1, w: 16'd3});
    ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    n = 0;
    while (!ifb.timeout && n < 6000) begin
      cyc(1);
      n++;
    end
    $display("arm timeout after %0d cycles", n);
    chk("arm_to_latency", 32'(n >= 4999 && n <= 5001), 1);
    chk("arm_to_busy", 32'(ifb.busy), 0);
    chk("arm_to_width", 32'(ifb.width_us), 3);
    cyc(5);

    // MEASURE timeout with echo held high for 10000 cycles
    ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    cyc(10);
    qb.push_back('{to: 1'b1, w: 16'd3});
    ifb.echo = 1'b1;
    n = 0;
    while (!ifb.timeout && n < 10000) begin
      cyc(1);
      n++;
    end
    $display("measure timeout after %0d cycles", n);
    chk("meas_to_latency", 32'(n >= 5003 && n <= 5005), 1);
    chk("meas_to_busy", 32'(ifb.busy), 0);
    cyc(10000 - n);
    ifb.echo = 1'b0;
    cyc(20);
    chk("meas_to_idle", 32'(ifb.busy), 0);
    chk("meas_to_width", 32'(ifb.width_us), 3);
    ifb.start = 1'b1;
    cyc(1);
    ifb.start = 1'b0;
    cyc(10);
    qb.push_back('{to: 1'b0, w: 16'd10});
    ifb.echo = 1'b1;
    cyc(1000);
    ifb.echo = 1'b0;
    cyc(10);
    chk("after_to_width", 32'(ifb.width_us), 10);

    // reset 1000 cycles into MEASURE
    ifa.start = 1'b1;
    cyc(1);
    ifa.start = 1'b0;
    cyc(10);
    ifa.echo = 1'b1;
    cyc(1003);
    chk("pre_rst_busy", 32'(ifa.busy), 1);
    rst = 1'b0;
    #1;
    chk("mrst_width", 32'(ifa.width_us), 0);
    chk("mrst_valid", 32'(ifa.valid), 0);
    chk("mrst_timeout", 32'(ifa.timeout), 0);
    chk("mrst_busy", 32'(ifa.busy), 0);
    cyc(5);
    ifa.echo = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(200);
    chk("post_rst_busy", 32'(ifa.busy), 0);
    ifa.echo = 1'b1;
    cyc(50);
    ifa.echo = 1'b0;
    cyc(10);
    chk("post_rst_idle", 32'(ifa.busy), 0);
    chk("post_rst_width", 32'(ifa.width_us), 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
